// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive stage: FSM states, default bit divisors
// and the clock-enable derivation.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rxState_t;

   localparam int BAUD_DIV0_DEFAULT = 61;
   localparam int BAUD_DIV1_DEFAULT = 56;

   function automatic logic ceFromPhases(input logic div2, input logic div4);
      return div2 & div4;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Register-side byte/status path between the receiver and the UARTDATA/UARTSTAT reads.
interface uart_rx_if;
   logic       data_read;
   logic [7:0] rxdata;
   logic       rxrecv;
   logic       ferr;
   logic       ovr;

   modport master (output data_read, input rxdata, rxrecv, ferr, ovr);
   modport slave  (input data_read, output rxdata, rxrecv, ferr, ovr);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle-high level.
module uart_rx_sync (
   input  logic clk_bus,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_bus) begin
      if (reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: holds each byte until the CPU read completes, drives rts
// and keeps sticky framing/overrun flags.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int BAUD_DIV0 = BAUD_DIV0_DEFAULT,
   parameter int BAUD_DIV1 = BAUD_DIV1_DEFAULT
) (
   input  logic      clk_bus,
   input  logic      reset,
   input  logic      clk_div2,
   input  logic      clk_div4,
   input  logic      ds80,
   input  logic      rx,
   output logic      rts,
   uart_rx_if.slave  bus
);

   localparam logic [7:0] DIV0 = 8'(BAUD_DIV0);
   localparam logic [7:0] DIV1 = 8'(BAUD_DIV1);

   rxState_t   state_q;
   logic [7:0] cnt_q;
   logic [7:0] div_q;
   logic [2:0] bitIdx_q;
   logic [7:0] shift_q;
   logic       rxPrev_q;
   logic       dataRead_q;
   logic [7:0] rxdata_q;
   logic       rxrecv_q;
   logic       ferr_q;
   logic       ovr_q;

   logic       rxSync;
   logic       ce;
   logic       readFall;
   logic       expired;
   logic [7:0] divSel;

   uart_rx_sync rxSyncInst (
      .clk_bus (clk_bus),
      .reset   (reset),
      .d_i     (rx),
      .q_o     (rxSync)
   );

   assign ce       = ceFromPhases(clk_div2, clk_div4);
   assign readFall = dataRead_q & ~bus.data_read;
   assign expired  = (cnt_q == 8'd1);
   assign divSel   = ds80 ? DIV1 : DIV0;

   // Later assignments win: a stop-bit event overrides the read-clear on the same ce,
   // and the read-clear frees the holding register for a byte landing on that ce.
   always_ff @(posedge clk_bus) begin
      if (reset) begin
         state_q    <= RX_IDLE;
         cnt_q      <= 8'd0;
         div_q      <= DIV0;
         bitIdx_q   <= 3'd0;
         shift_q    <= 8'h00;
         rxPrev_q   <= 1'b1;
         dataRead_q <= 1'b0;
         rxdata_q   <= 8'h00;
         rxrecv_q   <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else if (ce) begin
         rxPrev_q   <= rxSync;
         dataRead_q <= bus.data_read;
         if (readFall) begin
            rxrecv_q <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
         end
         case (state_q)
            RX_IDLE: begin
               if (rxPrev_q && !rxSync) begin
                  state_q <= RX_START;
                  div_q   <= divSel;
                  cnt_q   <= {1'b0, divSel[7:1]};
               end
            end
            RX_START: begin
               if (expired) begin
                  if (!rxSync) begin
                     state_q  <= RX_DATA;
                     cnt_q    <= div_q;
                     bitIdx_q <= 3'd0;
                  end else begin
                     state_q <= RX_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            RX_DATA: begin
               if (expired) begin
                  shift_q  <= {rxSync, shift_q[7:1]};
                  cnt_q    <= div_q;
                  bitIdx_q <= bitIdx_q + 3'd1;
                  if (bitIdx_q == 3'd7) begin
                     state_q <= RX_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            RX_STOP: begin
               if (expired) begin
                  if (rxSync) begin
                     if (!rxrecv_q || readFall) begin
                        rxdata_q <= shift_q;
                        rxrecv_q <= 1'b1;
                     end else begin
                        ovr_q <= 1'b1;
                     end
                     state_q <= RX_IDLE;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= RX_BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            RX_BREAK: begin
               if (rxSync) begin
                  state_q <= RX_IDLE;
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   assign rts        = rxrecv_q;
   assign bus.rxdata = rxdata_q;
   assign bus.rxrecv = rxrecv_q;
   assign bus.ferr   = ferr_q;
   assign bus.ovr    = ovr_q;

endmodule
